// File: rtl/aes_sched_pack.sv
// Shared types for the AES-CTR channel scheduler.
// State encoding, block and key/sync bundle types, arbiter helper.
package aes_sched_pack;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  typedef struct packed {
    block_t key;
    block_t sync;
  } ks_t;

  // Channel index `off` places after `base`, wrapping at n.
  function automatic int rr_idx(int base, int off, int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/aes_ctr_channel_scheduler_if.sv
// Handshake bundles used by the scheduler ports.
// Avalon-ST style stream and a plain data/valid/ready channel.
interface avalon_st_if #(
  parameter int W = 128
);
  logic         valid;
  logic         ready;
  logic         sop;
  logic         eop;
  logic [W-1:0] data;

  modport master (
    output valid, data, sop, eop,
    input  ready
  );

  modport slave (
    input  valid, data, sop, eop,
    output ready
  );
endinterface

interface dvr_if #(
  parameter int W = 256
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid, data,
    input  ready
  );

  modport slave (
    input  valid, data,
    output ready
  );
endinterface

// File: rtl/aes_tag_fifo.sv
// Small synchronous FIFO holding channel tags of packets in flight.
// Push and pop may coincide when full or empty.
module aes_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/aes_ctr_channel_scheduler.sv
// Time-shares one AES-CTR engine between N_CH channels.
// Round-robin per packet, per-channel key/sync, tagged return path.
module aes_ctr_channel_scheduler
  import aes_sched_pack::*;
#(
  parameter  int N_CH      = 4,
  parameter  int TAG_DEPTH = 4,
  localparam int CW        = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_vld,
  input  logic [CW-1:0]          cfg_ch,
  input  logic [127:0]           cfg_key,
  input  logic [127:0]           cfg_sync,
  output logic                   cfg_rdy,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH-1:0][127:0] ch_data,
  input  logic [N_CH-1:0]        ch_sop,
  input  logic [N_CH-1:0]        ch_eop,
  output logic [N_CH-1:0]        ch_ready,
  avalon_st_if.master            aes_in_st,
  dvr_if.master                  aes_ks,
  input  logic                   aes_ks_req,
  avalon_st_if.slave             aes_out_st,
  avalon_st_if.master            out_st,
  output logic [CW-1:0]          out_ch,
  output logic                   sync_wrap_irq,
  output logic [CW-1:0]          wrap_ch
);

  state_t          state;
  logic [CW-1:0]   gnt;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   idx;
  logic            found;
  logic            ks_vld;
  block_t          key_q  [N_CH];
  block_t          sync_q [N_CH];
  logic [N_CH-1:0] ctx_ok;
  logic [N_CH-1:0] elig;
  logic            fifo_full;
  logic            fifo_empty;
  logic            in_fire;
  logic            ks_fire;
  logic            cfg_fire;
  logic            tag_pop;
  logic            irq;
  logic [CW-1:0]   wrap_q;
  ks_t             ks;

  // The engine reloads only at packet boundaries, driven by LOAD;
  // its mid-packet requests carry no extra information here.
  logic unused;
  assign unused = aes_ks_req;

  assign elig     = ctx_ok & ch_valid & ch_sop
                  & {N_CH{!fifo_full}};
  assign cfg_rdy  = !((state != IDLE) && (cfg_ch == gnt));
  assign cfg_fire = cfg_vld && cfg_rdy
                  && (int'(cfg_ch) < N_CH);
  assign ks_fire  = ks_vld && aes_ks.ready;
  assign in_fire  = aes_in_st.valid && aes_in_st.ready;

  assign ks.key      = key_q[gnt];
  assign ks.sync     = sync_q[gnt];
  assign aes_ks.valid = ks_vld;
  assign aes_ks.data  = ks;

  assign aes_in_st.valid = (state == STREAM) && ch_valid[gnt];
  assign aes_in_st.data  = ch_data[gnt];
  assign aes_in_st.sop   = ch_sop[gnt];
  assign aes_in_st.eop   = ch_eop[gnt];

  assign out_st.valid     = aes_out_st.valid;
  assign out_st.data      = aes_out_st.data;
  assign out_st.sop       = aes_out_st.sop;
  assign out_st.eop       = aes_out_st.eop;
  assign aes_out_st.ready = out_st.ready;
  assign tag_pop = out_st.valid && out_st.ready
                && out_st.eop;

  assign sync_wrap_irq = irq;
  assign wrap_ch       = wrap_q;

  // Only the granted channel sees backpressure during STREAM.
  always_comb begin
    ch_ready = '0;
    if (state == STREAM) begin
      ch_ready[gnt] = aes_in_st.ready;
    end
  end

  // Round-robin pick starting at ptr.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = CW'(rr_idx(int'(ptr), i, N_CH));
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Packet-level FSM: arbitrate, load context, stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      ptr    <= '0;
      ks_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt    <= pick;
            ptr    <= CW'(rr_idx(int'(pick), 1, N_CH));
            ks_vld <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (aes_ks.ready) begin
            ks_vld <= 1'b0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (in_fire && ch_eop[gnt]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Context file: cfg writes and sync advance per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_ok <= '0;
      irq    <= 1'b0;
      wrap_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        key_q[i]  <= '0;
        sync_q[i] <= '0;
      end
    end else begin
      irq <= 1'b0;
      if (cfg_fire) begin
        key_q[cfg_ch]  <= cfg_key;
        sync_q[cfg_ch] <= cfg_sync;
        ctx_ok[cfg_ch] <= 1'b1;
      end
      if (in_fire) begin
        sync_q[gnt] <= sync_q[gnt] + block_t'(1);
        if (&sync_q[gnt]) begin
          ctx_ok[gnt] <= 1'b0;
          irq         <= 1'b1;
          wrap_q      <= gnt;
        end
      end
    end
  end

  aes_tag_fifo #(
    .W     (CW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ks_fire),
    .din   (gnt),
    .pop   (tag_pop),
    .dout  (out_ch),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_aes_ctr_channel_scheduler.sv
// Directed bench for aes_ctr_channel_scheduler.
// Vector table plus hand sequences; engine return modelled by a tag scoreboard.
module tb_aes_ctr_channel_scheduler;
  import aes_sched_pack::*;

  localparam int N_CH = 4;
  localparam int TD   = 4;
  localparam int CW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   cfg_vld;
  logic [CW-1:0]          cfg_ch;
  logic [127:0]           cfg_key;
  logic [127:0]           cfg_sync;
  logic                   cfg_rdy;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH-1:0][127:0] ch_data;
  logic [N_CH-1:0]        ch_sop;
  logic [N_CH-1:0]        ch_eop;
  logic [N_CH-1:0]        ch_ready;
  logic                   aes_ks_req;
  logic [CW-1:0]          out_ch;
  logic                   sync_wrap_irq;
  logic [CW-1:0]          wrap_ch;

  avalon_st_if #(.W(128)) aes_in_st ();
  dvr_if       #(.W(256)) aes_ks ();
  avalon_st_if #(.W(128)) aes_out_st ();
  avalon_st_if #(.W(128)) out_st ();

  aes_ctr_channel_scheduler #(
    .N_CH      (N_CH),
    .TAG_DEPTH (TD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_vld       (cfg_vld),
    .cfg_ch        (cfg_ch),
    .cfg_key       (cfg_key),
    .cfg_sync      (cfg_sync),
    .cfg_rdy       (cfg_rdy),
    .ch_valid      (ch_valid),
    .ch_data       (ch_data),
    .ch_sop        (ch_sop),
    .ch_eop        (ch_eop),
    .ch_ready      (ch_ready),
    .aes_in_st     (aes_in_st),
    .aes_ks        (aes_ks),
    .aes_ks_req    (aes_ks_req),
    .aes_out_st    (aes_out_st),
    .out_st        (out_st),
    .out_ch        (out_ch),
    .sync_wrap_irq (sync_wrap_irq),
    .wrap_ch       (wrap_ch)
  );

  typedef struct {
    int ch;
    int beats;
  } tag_t;

  typedef struct {
    int           ch;
    int           beats;
    bit           do_cfg;
    logic [127:0] cfg_sync;
    logic [127:0] exp_sync;
  } vec_t;

  int     n_vec = 0;
  int     n_bad = 0;
  tag_t   exp_q[$];
  int     ks_log[$];
  int     ret_beat = 0;
  bit     auto_ret = 0;
  block_t m_sync [N_CH];
  int     pkt_len [N_CH];
  int     ks_cnt = 0;
  int     beat_cnt = 0;
  int     irq_cnt = 0;
  int     last_ks_ch = -1;
  block_t last_ks_sync;
  int     last_wrap = -1;
  bit     beat_fire;
  bit     cfg_fire;
  int     beat_ch;

  function automatic block_t kval(int ch);
    return {96'hC0FFEE00_11223344_55667788, 32'(ch)};
  endfunction

  task automatic chk(string name, logic [255:0] act,
                     logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // One clock: drive the engine return, sample handshakes that
  // fire on the coming edge, advance to 1 unit past that edge.
  task automatic tick();
    if (auto_ret && exp_q.size() > 0) begin
      aes_out_st.valid = 1'b1;
      aes_out_st.sop   = (ret_beat == 0);
      aes_out_st.eop   = (ret_beat == exp_q[0].beats - 1);
      aes_out_st.data  = 128'(ret_beat + 100);
    end else begin
      aes_out_st.valid = 1'b0;
      aes_out_st.sop   = 1'b0;
      aes_out_st.eop   = 1'b0;
    end
    #1;
    beat_fire = 1'b0;
    cfg_fire  = 1'b0;
    if (aes_ks.valid && aes_ks.ready) begin
      int c;
      c = int'(aes_ks.data[159:128]);
      ks_cnt++;
      ks_log.push_back(c);
      last_ks_ch   = c;
      last_ks_sync = aes_ks.data[127:0];
      if (c < 0 || c >= N_CH) begin
        n_vec++;
        n_bad++;
        $display("FAIL ks_key: got %0h not a channel key",
                 aes_ks.data[255:128]);
      end else begin
        chk("ks_sync", aes_ks.data[127:0], m_sync[c]);
        exp_q.push_back('{ch: c, beats: pkt_len[c]});
      end
    end
    if (aes_in_st.valid && aes_in_st.ready) begin
      beat_fire = 1'b1;
      beat_ch   = -1;
      for (int i = 0; i < N_CH; i++) begin
        if (ch_ready[i]) beat_ch = i;
      end
      beat_cnt++;
      if (beat_ch < 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL beat_ready: got %0h expected one-hot",
                 ch_ready);
      end else begin
        chk("in_data", aes_in_st.data, ch_data[beat_ch]);
        chk("in_eop", aes_in_st.eop, ch_eop[beat_ch]);
        m_sync[beat_ch] = m_sync[beat_ch] + 1;
      end
    end
    if (out_st.valid && out_st.ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL out_beat: got beat with tag %0d expected none",
                 out_ch);
      end else begin
        chk("out_ch", out_ch, exp_q[0].ch);
        if (out_st.eop) begin
          void'(exp_q.pop_front());
          ret_beat = 0;
        end else begin
          ret_beat++;
        end
      end
    end
    if (cfg_vld && cfg_rdy) begin
      cfg_fire       = 1'b1;
      m_sync[cfg_ch] = cfg_sync;
    end
    @(posedge clk);
    #1;
    if (sync_wrap_irq) begin
      irq_cnt++;
      last_wrap = int'(wrap_ch);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    ret_beat = 0;
    for (int i = 0; i < N_CH; i++) m_sync[i] = '0;
  endtask

  task automatic check_reset(string t);
    chk({t, "_cfg_rdy"}, cfg_rdy, 1);
    chk({t, "_ch_ready"}, ch_ready, 0);
    chk({t, "_in_valid"}, aes_in_st.valid, 0);
    chk({t, "_ks_valid"}, aes_ks.valid, 0);
    chk({t, "_out_valid"}, out_st.valid, 0);
    chk({t, "_out_ch"}, out_ch, 0);
    chk({t, "_irq"}, sync_wrap_irq, 0);
    chk({t, "_wrap_ch"}, wrap_ch, 0);
  endtask

  task automatic cfg_write(int ch, block_t s);
    bit done = 0;
    cfg_vld  = 1'b1;
    cfg_ch   = CW'(ch);
    cfg_key  = kval(ch);
    cfg_sync = s;
    for (int g = 0; g < 20 && !done; g++) begin
      tick();
      done = cfg_fire;
    end
    cfg_vld = 1'b0;
    chk("cfg_accept", done, 1);
  endtask

  task automatic set_beat(int ch, int n, int beats);
    ch_sop[ch]  = (n == 0);
    ch_eop[ch]  = (n == beats - 1);
    ch_data[ch] = {32'hDA7A0000 + 32'(ch), 96'(n)};
  endtask

  task automatic send_pkt(int ch, int beats, output int ticks);
    int sent = 0;
    ticks = 0;
    pkt_len[ch]  = beats;
    ch_valid[ch] = 1'b1;
    set_beat(ch, 0, beats);
    while (sent < beats && ticks < 40) begin
      tick();
      ticks++;
      if (beat_fire) begin
        sent++;
        set_beat(ch, sent, beats);
      end
    end
    ch_valid[ch] = 1'b0;
    ch_sop[ch]   = 1'b0;
    ch_eop[ch]   = 1'b0;
    if (sent < beats) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_pkt ch%0d: got %0d beats expected %0d",
               ch, sent, beats);
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 50 && exp_q.size() > 0; g++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  // Hold 1-beat packets on the channels in mask until n beats go.
  task automatic run_beats(logic [N_CH-1:0] mask, int n);
    int b0 = beat_cnt;
    for (int i = 0; i < N_CH; i++) begin
      if (mask[i]) begin
        pkt_len[i]  = 1;
        ch_valid[i] = 1'b1;
        set_beat(i, 0, 1);
      end
    end
    for (int g = 0; g < 200 && beat_cnt - b0 < n; g++) tick();
    ch_valid = '0;
    ch_sop   = '0;
    ch_eop   = '0;
    chk("run_beats", beat_cnt - b0, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt [5];
    int   rr_exp [6];
    int   t;
    int   ks0;
    int   b0;
    int   i0;
    int   n0;

    vt[0] = '{1, 3, 1'b1, 128'h10, 128'h10};
    vt[1] = '{0, 2, 1'b1, 128'h5, 128'h5};
    vt[2] = '{1, 1, 1'b0, 128'h0, 128'h13};
    vt[3] = '{0, 1, 1'b0, 128'h0, 128'h7};
    vt[4] = '{2, 1, 1'b1, {{127{1'b1}}, 1'b0},
              {{127{1'b1}}, 1'b0}};
    rr_exp = '{0, 2, 3, 0, 2, 3};

    rst              = 1'b0;
    cfg_vld          = 1'b0;
    cfg_ch           = '0;
    cfg_key          = '0;
    cfg_sync         = '0;
    ch_valid         = '0;
    ch_data          = '0;
    ch_sop           = '0;
    ch_eop           = '0;
    aes_ks_req       = 1'b0;
    aes_in_st.ready  = 1'b1;
    aes_ks.ready     = 1'b1;
    out_st.ready     = 1'b1;
    aes_out_st.valid = 1'b0;
    aes_out_st.sop   = 1'b0;
    aes_out_st.eop   = 1'b0;
    aes_out_st.data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      m_sync[i]  = '0;
      pkt_len[i] = 1;
    end

    do_reset();
    check_reset("rst0");

    // Round-robin over channels 0, 2, 3 from a fresh pointer.
    auto_ret = 1'b1;
    for (int i = 0; i < N_CH; i++) cfg_write(i, '0);
    n0 = ks_log.size();
    run_beats(4'b1101, 6);
    for (int i = 0; i < 6; i++) begin
      if (n0 + i < ks_log.size())
        chk("rr_order", ks_log[n0 + i], rr_exp[i]);
      else
        chk("rr_order_missing", ks_log.size(), n0 + 6);
    end
    drain();

    // Table: single packets with context resume.
    for (int v = 0; v < 5; v++) begin
      if (vt[v].do_cfg) cfg_write(vt[v].ch, vt[v].cfg_sync);
      ks0 = ks_cnt;
      b0  = beat_cnt;
      i0  = irq_cnt;
      send_pkt(vt[v].ch, vt[v].beats, t);
      chk("vec_loads", ks_cnt - ks0, 1);
      chk("vec_ks_ch", last_ks_ch, vt[v].ch);
      chk("vec_ks_sync", last_ks_sync, vt[v].exp_sync);
      chk("vec_beats", beat_cnt - b0, vt[v].beats);
      chk("vec_latency", t, vt[v].beats + 2);
      chk("vec_no_irq", irq_cnt - i0, 0);
      drain();
    end

    // Sync wrap on channel 3 and lockout until reconfigured.
    i0 = irq_cnt;
    cfg_write(3, '1);
    send_pkt(3, 2, t);
    tick();
    tick();
    chk("wrap_ks_sync", last_ks_sync, {128{1'b1}});
    chk("wrap_irq_count", irq_cnt - i0, 1);
    chk("wrap_ch", last_wrap, 3);
    drain();
    ks0 = ks_cnt;
    pkt_len[3]  = 1;
    ch_valid[3] = 1'b1;
    set_beat(3, 0, 1);
    repeat (10) tick();
    chk("wrap_lockout", ks_cnt - ks0, 0);
    cfg_write(3, 128'h40);
    b0 = beat_cnt;
    for (int g = 0; g < 20 && beat_cnt == b0; g++) tick();
    ch_valid[3] = 1'b0;
    ch_sop[3]   = 1'b0;
    ch_eop[3]   = 1'b0;
    chk("wrap_regrant_ch", last_ks_ch, 3);
    chk("wrap_regrant_sync", last_ks_sync, 128'h40);
    drain();

    // Tag FIFO full with return path stalled.
    auto_ret     = 1'b0;
    out_st.ready = 1'b0;
    ks0 = ks_cnt;
    n0  = ks_log.size();
    pkt_len[0]  = 1;
    pkt_len[1]  = 1;
    ch_valid    = 4'b0011;
    set_beat(0, 0, 1);
    set_beat(1, 0, 1);
    repeat (30) tick();
    chk("full_loads", ks_cnt - ks0, TD);
    chk("full_ks_idle", aes_ks.valid, 0);
    chk("full_ready_idle", ch_ready, 0);
    chk("full_head", out_ch, 0);
    chk("full_out_valid", out_st.valid, 0);
    chk("full_ready_pass", aes_out_st.ready, 0);
    ch_valid = '0;
    ch_sop   = '0;
    ch_eop   = '0;
    out_st.ready = 1'b1;
    auto_ret     = 1'b1;
    #1;
    chk("ready_pass", aes_out_st.ready, 1);
    run_beats(4'b0011, 2);
    chk("resume_loads", ks_cnt - ks0, TD + 2);
    drain();

    // Config stall while channel 0 is streaming.
    pkt_len[0]  = 3;
    ch_valid[0] = 1'b1;
    set_beat(0, 0, 3);
    ks0 = ks_cnt;
    for (int g = 0; g < 10 && ks_cnt == ks0; g++) tick();
    aes_ks_req = 1'b1;
    cfg_ch = 2'd1;
    #1;
    chk("cfg_rdy_other", cfg_rdy, 1);
    cfg_vld  = 1'b1;
    cfg_ch   = 2'd0;
    cfg_key  = kval(0);
    cfg_sync = 128'h99;
    #1;
    chk("cfg_rdy_stall", cfg_rdy, 0);
    b0 = beat_cnt;
    for (int g = 0; g < 10 && beat_cnt - b0 < 2; g++) begin
      tick();
      if (beat_fire) set_beat(0, beat_cnt - b0, 3);
      chk("cfg_stall_nofire", cfg_fire, 0);
    end
    aes_ks_req = 1'b0;
    #1;
    chk("cfg_rdy_eop", cfg_rdy, 0);
    tick();
    chk("cfg_eop_beat", beat_fire, 1);
    chk("cfg_rdy_after", cfg_rdy, 1);
    ch_valid[0] = 1'b0;
    ch_sop[0]   = 1'b0;
    ch_eop[0]   = 1'b0;
    tick();
    chk("cfg_late_fire", cfg_fire, 1);
    cfg_vld = 1'b0;
    send_pkt(0, 1, t);
    chk("cfg_new_sync", last_ks_sync, 128'h99);
    drain();

    // Reset in the middle of a stream.
    auto_ret    = 1'b0;
    pkt_len[1]  = 3;
    ch_valid[1] = 1'b1;
    set_beat(1, 0, 3);
    ks0 = ks_cnt;
    for (int g = 0; g < 10 && ks_cnt == ks0; g++) tick();
    tick();
    set_beat(1, 1, 3);
    chk("pre_rst_tag", out_ch, 1);
    chk("pre_rst_wrap", wrap_ch, 3);
    chk("pre_rst_stream", ch_ready, 4'b0010);
    do_reset();
    check_reset("rst1");
    ks0 = ks_cnt;
    b0  = beat_cnt;
    set_beat(1, 0, 3);
    repeat (5) tick();
    chk("post_rst_loads", ks_cnt - ks0, 0);
    chk("post_rst_beats", beat_cnt - b0, 0);
    ch_valid = '0;
    ch_sop   = '0;
    ch_eop   = '0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
